// File: rtl/cga_idbctl_src_seq_if.sv
// Source-select handshake between a requester and the IDB source sequencer.
// The master drives the request and source code; the slave returns ack, error and busy.
interface cga_idbctl_src_seq_if;
    logic       sel_req;
    logic [2:0] sel_src;
    logic       sel_ack;
    logic       err_bad_src;
    logic       busy;

    modport master (
        output sel_req,
        output sel_src,
        input  sel_ack,
        input  err_bad_src,
        input  busy
    );

    modport slave (
        input  sel_req,
        input  sel_src,
        output sel_ack,
        output err_bad_src,
        output busy
    );
endinterface

// File: rtl/cga_idbctl_src_seq.sv
// Sequencer gating one IDB bit-0 status source at a time: setup, drive, turnaround.
// Define IDBCTL_SRC_SNAPSHOT_EN to hold the status flags captured at accept while driving.
module cga_idbctl_src_seq #(
    parameter int DRIVE_CYCLES = 2,
    parameter int TURN_CYCLES  = 1,
    parameter int CW           = 4
) (
    input  logic                    sysclk,
    input  logic                    sys_rst_n,
    cga_idbctl_src_seq_if.slave     sel,
    input  logic                    d_in,
    input  logic                    m_in,
    input  logic                    v_in,
    input  logic                    s_in,
    input  logic                    pcr_in,
    input  logic                    pgs_in,
    output logic                    idb_oe,
    output logic [5:0]              e_pins,
    output logic                    d,
    output logic                    m,
    output logic                    v,
    output logic                    s,
    output logic                    pcr,
    output logic                    pgs
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRIVE,
        S_TURN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    e_pins_q, e_pins_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          oe_q, oe_d;
    logic [5:0]    dec;
    logic          legal;
    logic          accept;

    always_comb begin
        dec   = 6'b000000;
        legal = 1'b1;
        case (sel.sel_src)
            3'd0:    dec = 6'b000001;
            3'd1:    dec = 6'b000010;
            3'd2:    dec = 6'b000100;
            3'd3:    dec = 6'b001000;
            3'd4:    dec = 6'b010000;
            3'd5:    dec = 6'b100000;
            default: legal = 1'b0;
        endcase
    end

    // A request is not re-sampled in the cycle its error ack is shown.
    assign accept = (state_q == S_IDLE) && sel.sel_req && !ack_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        e_pins_d = e_pins_q;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                e_pins_d = 6'b000000;
                if (accept) begin
                    if (legal) begin
                        state_d  = S_SETUP;
                        e_pins_d = dec;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_DRIVE;
                cnt_d   = CW'(DRIVE_CYCLES - 1);
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    e_pins_d = 6'b000000;
                    if (TURN_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_TURN;
                        cnt_d   = CW'(TURN_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_TURN: begin
                e_pins_d = 6'b000000;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Ack lands in the drive cycle whose count reads zero.
        ack_d  = err_d | ((state_d == S_DRIVE) && (cnt_d == '0));
        busy_d = (state_d != S_IDLE);
        oe_d   = (state_d == S_DRIVE);
    end

    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            e_pins_q <= 6'b000000;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            e_pins_q <= e_pins_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            oe_q     <= oe_d;
        end
    end

    assign sel.sel_ack     = ack_q;
    assign sel.err_bad_src = err_q;
    assign sel.busy        = busy_q;
    assign idb_oe          = oe_q;
    assign e_pins          = e_pins_q;

`ifdef IDBCTL_SRC_SNAPSHOT_EN
    logic [5:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (accept && legal) begin
            flags_d = {d_in, m_in, v_in, s_in, pcr_in, pgs_in};
        end
    end

    always_ff @(posedge sysclk) begin
        if (!sys_rst_n) begin
            flags_q <= 6'b000000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign {d, m, v, s, pcr, pgs} = flags_q;
`else
    assign {d, m, v, s, pcr, pgs} = {d_in, m_in, v_in, s_in, pcr_in, pgs_in};
`endif

endmodule

// File: tb/tb_cga_idbctl_src_seq.sv
// Directed bench for the IDB source sequencer with default timing parameters.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_cga_idbctl_src_seq;
    logic       clk;
    logic       rst_n;
    logic       d_in, m_in, v_in, s_in, pcr_in, pgs_in;
    logic       idb_oe;
    logic [5:0] e_pins;
    logic       d, m, v, s, pcr, pgs;
    int         n_cmp;
    int         n_bad;

    cga_idbctl_src_seq_if bus ();

    cga_idbctl_src_seq dut (
        .sysclk    (clk),
        .sys_rst_n (rst_n),
        .sel       (bus.slave),
        .d_in      (d_in),
        .m_in      (m_in),
        .v_in      (v_in),
        .s_in      (s_in),
        .pcr_in    (pcr_in),
        .pgs_in    (pgs_in),
        .idb_oe    (idb_oe),
        .e_pins    (e_pins),
        .d         (d),
        .m         (m),
        .v         (v),
        .s         (s),
        .pcr       (pcr),
        .pgs       (pgs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // e_pins, idb_oe, sel_ack, busy in one go
    task automatic chk_st(input string tag, input logic [5:0] ep, input logic oe,
                          input logic ack, input logic bsy);
        chk({tag, ".e_pins"}, {2'b00, e_pins}, {2'b00, ep});
        chk({tag, ".idb_oe"}, {7'd0, idb_oe}, {7'd0, oe});
        chk({tag, ".ack"}, {7'd0, bus.sel_ack}, {7'd0, ack});
        chk({tag, ".busy"}, {7'd0, bus.busy}, {7'd0, bsy});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        {d_in, m_in, v_in, s_in, pcr_in, pgs_in} = 6'b000000;
        bus.sel_req = 1'b1;
        bus.sel_src = 3'd3;
        rst_n = 1'b0;

        // 1: reset held two cycles with a pending request
        tick();
        tick();
        chk_st("rst", 6'b000000, 1'b0, 1'b0, 1'b0);
        chk("rst.err", {7'd0, bus.err_bad_src}, 8'd0);
        chk("rst.flags", {2'b00, d, m, v, s, pcr, pgs}, 8'd0);

        // 2: src 3, request sampled at the next edge
        rst_n = 1'b1;
        tick();
        chk_st("t2.c1", 6'b001000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t2.c2", 6'b001000, 1'b1, 1'b0, 1'b1);
        tick();
        chk_st("t2.c3", 6'b001000, 1'b1, 1'b1, 1'b1);
        chk("t2.c3.err", {7'd0, bus.err_bad_src}, 8'd0);
        bus.sel_req = 1'b0;
        tick();
        chk_st("t2.c4", 6'b000000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t2.c5", 6'b000000, 1'b0, 1'b0, 1'b0);

        // 3: illegal source code
        bus.sel_req = 1'b1;
        bus.sel_src = 3'd6;
        tick();
        chk_st("t3.c1", 6'b000000, 1'b0, 1'b1, 1'b0);
        chk("t3.c1.err", {7'd0, bus.err_bad_src}, 8'd1);
        bus.sel_req = 1'b0;
        tick();
        chk_st("t3.c2", 6'b000000, 1'b0, 1'b0, 1'b0);
        chk("t3.c2.err", {7'd0, bus.err_bad_src}, 8'd0);

        // 4: request held across two sequences, src 5 then 0
        bus.sel_req = 1'b1;
        bus.sel_src = 3'd5;
        tick();
        chk_st("t4.a1", 6'b100000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t4.a2", 6'b100000, 1'b1, 1'b0, 1'b1);
        tick();
        chk_st("t4.a3", 6'b100000, 1'b1, 1'b1, 1'b1);
        bus.sel_src = 3'd0;
        tick();
        chk_st("t4.a4", 6'b000000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t4.idle", 6'b000000, 1'b0, 1'b0, 1'b0);
        tick();
        chk_st("t4.b1", 6'b000001, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t4.b2", 6'b000001, 1'b1, 1'b0, 1'b1);
        tick();
        chk_st("t4.b3", 6'b000001, 1'b1, 1'b1, 1'b1);
        bus.sel_req = 1'b0;
        tick();
        chk_st("t4.b4", 6'b000000, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t4.b5", 6'b000000, 1'b0, 1'b0, 1'b0);

        // 5: reset during DRIVE aborts; request accepted after release
        bus.sel_req = 1'b1;
        bus.sel_src = 3'd2;
        tick();
        chk_st("t5.c1", 6'b000100, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t5.c2", 6'b000100, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_st("t5.rst", 6'b000000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_st("t5.r1", 6'b000100, 1'b0, 1'b0, 1'b1);
        tick();
        chk_st("t5.r2", 6'b000100, 1'b1, 1'b0, 1'b1);
        tick();
        chk_st("t5.r3", 6'b000100, 1'b1, 1'b1, 1'b1);
        bus.sel_req = 1'b0;
        tick();
        tick();
        chk_st("t5.end", 6'b000000, 1'b0, 1'b0, 1'b0);

        // 6: v_in toggling while src 3 is driven
        v_in = 1'b1;
        bus.sel_req = 1'b1;
        bus.sel_src = 3'd3;
        tick();
        v_in = 1'b0;
        #1;
`ifdef IDBCTL_SRC_SNAPSHOT_EN
        chk("t6.snap.c1", {7'd0, v}, 8'd1);
        tick();
        chk("t6.snap.c2", {7'd0, idb_oe}, 8'd1);
        v_in = 1'b1;
        #1;
        chk("t6.snap.c2b", {7'd0, v}, 8'd1);
        v_in = 1'b0;
        tick();
        chk("t6.snap.c3", {7'd0, v}, 8'd1);
`else
        chk("t6.pass.c1", {7'd0, v}, 8'd0);
        tick();
        chk("t6.pass.c2", {7'd0, idb_oe}, 8'd1);
        v_in = 1'b1;
        #1;
        chk("t6.pass.c2b", {7'd0, v}, 8'd1);
        d_in = 1'b1;
        pgs_in = 1'b1;
        #1;
        chk("t6.pass.all", {2'b00, d, m, v, s, pcr, pgs}, 8'b00101001);
        tick();
`endif
        chk("t6.ack", {7'd0, bus.sel_ack}, 8'd1);
        bus.sel_req = 1'b0;
        tick();
        tick();
        chk_st("t6.end", 6'b000000, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
